// File: rtl/display_pkg.sv
// Shared types, defaults and helpers for the seven-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    OFF,
    BLANK,
    SHOW
  } scan_state_t;

  localparam int unsigned MAX_DIGITS       = 8;
  localparam int unsigned DEF_NUM_DIGITS   = 4;
  localparam int unsigned DEF_DWELL_CYCLES = 100000;
  localparam int unsigned DEF_BLANK_CYCLES = 1000;
  localparam int unsigned DEF_BLINK_FRAMES = 128;

  // Active-low one-hot anode pattern; positions at or above num_digits stay high.
  function automatic logic [MAX_DIGITS-1:0] anode_onehot_n(input logic [2:0]   sel,
                                                           input int unsigned num_digits);
    logic [MAX_DIGITS-1:0] an_n;
    an_n = '1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < num_digits && 3'(i) == sel) an_n[i] = 1'b0;
    end
    return an_n;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module scan_timer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= WIDTH'(RST_VAL);
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame latch and blink masking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [2:0]              sel,
  output logic [4*NUM_DIGITS-1:0] hex_word,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    blink_phase
);

  localparam int unsigned MAX_INTERVAL =
      (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned TW = $clog2(MAX_INTERVAL + 1);
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [2:0]    LAST_SEL   = 3'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES - 1);

  scan_state_t           state_q;
  logic                  tmr_load, tmr_dec, tmr_tc;
  logic [TW-1:0]         tmr_load_val;
  logic                  blink_load, blink_dec, blink_tc;
  logic                  frame_latch, digit_lit;
  logic [MAX_DIGITS-1:0] den_w, ben_w, an_sel_n;

  // Widen masks so a 3-bit sel can index them for any digit count.
  always_comb begin
    den_w = '0;
    ben_w = '0;
    den_w[NUM_DIGITS-1:0] = digit_en;
    ben_w[NUM_DIGITS-1:0] = blink_en;
    digit_lit = den_w[sel] && !(ben_w[sel] && !blink_phase);
    an_sel_n  = anode_onehot_n(sel, NUM_DIGITS);
  end

  // A frame latches on leaving OFF and on the last digit's dwell expiry.
  assign frame_latch = en && ((state_q == OFF) ||
                              (state_q == SHOW && tmr_tc && sel == LAST_SEL));

  // Interval timer: counts the blank gap and the dwell; the entry cycle counts as the first.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = '0;
    if (!en) begin
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        OFF: begin
          tmr_load     = 1'b1;
          tmr_load_val = BLANK_LOAD;
        end
        BLANK: begin
          if (tmr_tc) begin
            tmr_load     = 1'b1;
            tmr_load_val = DWELL_LOAD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        SHOW: begin
          if (tmr_tc) begin
            tmr_load     = 1'b1;
            tmr_load_val = BLANK_LOAD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: tmr_load = 1'b1;
      endcase
    end
  end

  // The blink timer holds frames remaining until the next phase toggle.
  assign blink_dec  = frame_latch && !blink_tc;
  assign blink_load = frame_latch && blink_tc;

  scan_timer #(
    .WIDTH   (TW),
    .RST_VAL (0)
  ) u_interval (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .tc       (tmr_tc)
  );

  scan_timer #(
    .WIDTH   (BW),
    .RST_VAL (BLINK_FRAMES - 1)
  ) u_blink (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (blink_load),
    .load_val (BLINK_LOAD),
    .dec      (blink_dec),
    .tc       (blink_tc)
  );

  // Scan FSM with registered outputs; anodes follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OFF;
      sel         <= '0;
      hex_word    <= '0;
      an          <= '1;
      frame_start <= 1'b0;
      blink_phase <= 1'b1;
    end else begin
      frame_start <= frame_latch;
      if (frame_latch) hex_word <= data_in;
      if (blink_load) blink_phase <= ~blink_phase;
      if (!en) begin
        state_q <= OFF;
        sel     <= '0;
        an      <= '1;
      end else begin
        unique case (state_q)
          OFF: begin
            state_q <= BLANK;
            sel     <= '0;
            an      <= '1;
          end
          BLANK: begin
            if (tmr_tc) begin
              state_q <= SHOW;
              an      <= digit_lit ? an_sel_n[NUM_DIGITS-1:0] : '1;
            end else begin
              an <= '1;
            end
          end
          SHOW: begin
            if (tmr_tc) begin
              state_q <= BLANK;
              sel     <= (sel == LAST_SEL) ? 3'd0 : sel + 3'd1;
              an      <= '1;
            end else begin
              an <= digit_lit ? an_sel_n[NUM_DIGITS-1:0] : '1;
            end
          end
          default: begin
            state_q <= OFF;
            sel     <= '0;
            an      <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position model checked every cycle plus directed literals.
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int BLINK = 2;
  localparam int SLOT  = BLANK + DWELL;
  localparam int FRAME = ND * SLOT;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [4*ND-1:0]   data_in;
  logic [ND-1:0]     digit_en;
  logic [ND-1:0]     blink_en;
  logic [2:0]        sel;
  logic [4*ND-1:0]   hex_word;
  logic [ND-1:0]     an;
  logic              frame_start;
  logic              blink_phase;

  int n_checks = 0;
  int n_fail   = 0;

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .data_in     (data_in),
    .digit_en    (digit_en),
    .blink_en    (blink_en),
    .sel         (sel),
    .hex_word    (hex_word),
    .an          (an),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position inside the frame decides everything; blink phase from total latches.
  bit              m_run   = 1'b0;
  int              m_t     = 0;
  int              m_latch = 0;
  logic [4*ND-1:0] m_hex   = '0;
  logic            m_fs    = 1'b0;
  logic            m_blink = 1'b1;
  logic [ND-1:0]   m_an    = '1;
  logic [2:0]      m_sel   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_t = 0; m_latch = 0; m_hex = '0; m_fs = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (!en) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        m_run = 1'b1; m_t = 0;
        m_latch++; m_hex = data_in; m_fs = 1'b1;
      end else begin
        m_t++;
        if (m_t % FRAME == 0) begin
          m_latch++; m_hex = data_in; m_fs = 1'b1;
        end
      end
    end
    m_blink = ((m_latch / BLINK) % 2) == 0;
    m_an  = '1;
    m_sel = '0;
    if (m_run && rst_n) begin
      int p, d;
      p = m_t % FRAME;
      d = p / SLOT;
      m_sel = 3'(d);
      if ((p % SLOT) >= BLANK && digit_en[d] && !(blink_en[d] && !m_blink)) m_an[d] = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_an", 32'(an), 32'(m_an));
    chk("model_sel", 32'(sel), 32'(m_sel));
    chk("model_hex_word", 32'(hex_word), 32'(m_hex));
    chk("model_frame_start", 32'(frame_start), 32'(m_fs));
    chk("model_blink_phase", 32'(blink_phase), 32'(m_blink));
  end

  logic [3:0] exp_show [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    bit found;
    rst_n = 1'b1; en = 1'b1; data_in = 16'h1234; digit_en = 4'hF; blink_en = 4'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_hex", 32'(hex_word), 32'h0);
    chk("reset_blink", 32'(blink_phase), 32'h1);
    chk("reset_fs", 32'(frame_start), 32'h0);
    rst_n = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (frame_start) found = 1'b1;
    end
    chk("first_frame_start_seen", 32'(found), 32'h1);
    chk("first_hex", 32'(hex_word), 32'h1234);

    for (int k = 1; k <= 96; k++) begin
      @(negedge clk);
      if (k < FRAME && k % SLOT == BLANK) begin
        chk("scan_an", 32'(an), 32'(exp_show[k/SLOT]));
        chk("scan_sel", 32'(sel), k / SLOT);
      end
      if (k == 1 || k == 6 || k == 7) chk("blank_gap_an", 32'(an), 32'hF);
      if (k == 5) chk("dwell_last_an", 32'(an), 32'hE);
      if (k == 8) data_in = 16'hABCD;
      if (k == 23) begin
        chk("midframe_hex_hold", 32'(hex_word), 32'h1234);
        chk("no_early_fs", 32'(frame_start), 32'h0);
      end
      if (k == 24) begin
        chk("fs_at_24", 32'(frame_start), 32'h1);
        chk("hex_updated", 32'(hex_word), 32'hABCD);
        digit_en = 4'b1011;
        blink_en = 4'b0001;
      end
      if (k == 26) chk("digit0_blink_off", 32'(an), 32'hF);
      if (k == 30) chk("blink_phase_f1", 32'(blink_phase), 32'h0);
      if (k == 32) chk("digit1_lit", 32'(an), 32'hD);
      if (k == 38) chk("digit2_disabled", 32'(an), 32'hF);
      if (k == 48) chk("blink_phase_f2", 32'(blink_phase), 32'h0);
      if (k == 50) chk("digit0_blink_off2", 32'(an), 32'hF);
      if (k == 72) chk("blink_phase_f3", 32'(blink_phase), 32'h1);
      if (k == 74) chk("digit0_blink_on", 32'(an), 32'hE);
      if (k == 86) chk("digit2_disabled2", 32'(an), 32'hF);
      if (k == 96) begin
        digit_en = 4'hF;
        blink_en = 4'h0;
      end
    end

    for (int k = 97; k <= 111; k++) begin
      @(negedge clk);
      if (k == 110) begin
        chk("digit2_show", 32'(an), 32'hB);
        chk("digit2_sel", 32'(sel), 32'h2);
      end
    end
    en = 1'b0;
    @(negedge clk);
    chk("disable_an", 32'(an), 32'hF);
    chk("disable_sel", 32'(sel), 32'h0);
    chk("disable_blink_kept", 32'(blink_phase), 32'h1);
    chk("disable_hex_kept", 32'(hex_word), 32'hABCD);
    repeat (3) @(negedge clk);
    chk("off_no_fs", 32'(frame_start), 32'h0);
    en = 1'b1;
    @(negedge clk);
    chk("reenable_fs", 32'(frame_start), 32'h1);
    chk("reenable_sel", 32'(sel), 32'h0);
    repeat (2) @(negedge clk);
    chk("reenable_show", 32'(an), 32'hE);

    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_sel", 32'(sel), 32'h0);
    chk("async_hex", 32'(hex_word), 32'h0);
    chk("async_fs", 32'(frame_start), 32'h0);
    chk("async_blink", 32'(blink_phase), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed seven-segment scan controller for the alarm clock display. It owns the 3-bit digit select feeding the 16-bit-to-nibble display mux, and drives the active-low digit anodes. It latches the 16-bit display word once per frame to prevent tearing. It also applies per-digit enable and blink masks, used for the alarm/time-set modes, with a blanking gap between digits to suppress ghosting.

Parameters:
NUM_DIGITS, 4, digits scanned per frame (2..8); sel wraps at NUM_DIGITS-1
DWELL_CYCLES, 100000, clk cycles each digit anode is driven (>=1)
BLANK_CYCLES, 1000, clk cycles all anodes off before each digit (>=1)
BLINK_FRAMES, 128, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; low forces display dark
data_in  in  4*NUM_DIGITS  display word, digit i = data_in[4i+3:4i]
digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit never lit
blink_en  in  NUM_DIGITS  per-digit blink; 1 = digit dark during blink-off phase
sel  out  3  digit select to display mux
hex_word  out  4*NUM_DIGITS  frame-latched copy of data_in, feeds mux data input
an  out  NUM_DIGITS  anodes, active-low, at most one low
frame_start  out  1  one-cycle pulse when a new frame is latched
blink_phase  out  1  current blink phase, 1 = on

Behaviour:
- Reset (async assert, sync release):
  - sel=0, hex_word=0, an=all 1s, frame_start=0, blink_phase=1.
  - State=OFF; all counters 0.
- States: OFF, BLANK, SHOW. All outputs are registered.
- OFF:
  - an all 1s, sel=0, dwell counter and blink counter held.
  - en=1 → BLANK with sel=0: hex_word<=data_in, frame_start=1 for that cycle, blink frame counter advances.
- BLANK:
  - an all 1s.
  - Counts BLANK_CYCLES cycles (the cycle of entry counts as the first), then → SHOW.
- SHOW:
  - an[sel]=0 iff digit_en[sel]=1 AND NOT(blink_en[sel]=1 AND blink_phase=0); otherwise an stays all 1s.
  - digit_en and blink_en are sampled live each cycle, not frame-latched.
  - After DWELL_CYCLES cycles → BLANK with sel<=sel+1.
  - If sel==NUM_DIGITS-1, sel wraps to 0, and in the same cycle hex_word<=data_in, frame_start pulses, and the blink counter advances.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Latency: the anode first goes low BLANK_CYCLES cycles after leaving OFF.
- Blink: frame counter counts 0..BLINK_FRAMES-1. On each frame latch at count BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- en deasserted in any state → OFF on the next edge, with an all 1s in that same registered update.
  - hex_word retains its value.
  - sel and the dwell counter reset to 0.
  - blink_phase and the frame counter are preserved.
- hex_word changes only on a frame latch; data_in changes mid-frame are invisible until the next frame.
- sel never exceeds NUM_DIGITS-1.
- an is never low in BLANK or OFF, and never has two bits low, including across sel transitions.
- Counter width: $clog2 of max(DWELL_CYCLES, BLANK_CYCLES)+1. No overflow for legal parameters.

Decomposition:
- Shared package display_pkg:
  - State enum scan_state_t {OFF, BLANK, SHOW}.
  - Default DWELL/BLANK/BLINK constants.
  - Function anode_onehot_n(sel, NUM_DIGITS).
- One natural sub-module: scan_timer, a loadable down-counter with a terminal-count pulse, reused for the dwell/blank interval and for the blink frame count.
- The FSM and frame latch stay in display_scan_ctrl.

Test Plan:
- Bench parameters: NUM_DIGITS=4, DWELL=4, BLANK=2, BLINK_FRAMES=2.
- Reset check:
  - Stimulus: rst_n low with en=1, data_in=16'h1234.
  - Required: an=4'b1111, sel=0, hex_word=0, blink_phase=1.
  - Release rst_n, en=1: frame_start pulses once, hex_word=16'h1234.
  - an=4'b1110 from the third cycle after the pulse, for 4 cycles; then 2 cycles of 4'b1111.
- Full scan:
  - Stimulus: digit_en=4'hF, blink_en=0, one frame.
  - Required: an sequence 1110, 1101, 1011, 0111 with sel 0,1,2,3; next frame_start exactly 24 cycles after the first.
- Mid-frame update:
  - Stimulus: change data_in to 16'hABCD while sel=1.
  - Required: hex_word stays 16'h1234 until the next frame_start, then 16'hABCD.
- Masks:
  - Stimulus: digit_en=4'b1011, blink_en=4'b0001.
  - Required: digit 2 never lit. Digit 0 lit in frames with blink_phase=1 and dark for 2 frames when blink_phase=0. blink_phase toggles every 2 frame_starts.
- Disable mid-operation:
  - Stimulus: en deasserted during SHOW of digit 2.
  - Required: an=1111 next edge, sel=0; blink_phase retained. Re-enable: new frame_start, sel=0.
- Async reset mid-SHOW: an=1111 immediately without a clock edge; all outputs at their reset values.
